// File: rtl/change_trace_fifo_if.sv
// Trace output channel of change_trace_fifo: head entry plus valid/ready handshake.
// The tracer drives the master side; the consumer (logger, formatter, printer) is the slave.
interface change_trace_fifo_if #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned TS_W   = 16
);
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [TS_W-1:0]   out_ts;

   modport master (
      output out_valid,
      output out_data,
      output out_ts,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_ts,
      output out_ready
   );
endinterface

// File: rtl/change_trace_fifo.sv
// Value-change tracer: captures {mon_data, timestamp} on every change into a FWFT FIFO.
// Optional CHANGE_TRACE_DELTA_EN reports saturating cycles since the previous event instead.
module change_trace_fifo #(
   parameter int unsigned DATA_W = 4,
   parameter int unsigned TS_W   = 16,
   parameter int unsigned DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     en,
   input  logic [DATA_W-1:0]        mon_data,
   change_trace_fifo_if.master      trace,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [TS_W-1:0]   ts_q, ts_d;
   logic [DATA_W-1:0] prev_q, prev_d;
   logic              armed_q, armed_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;

   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [TS_W-1:0]   ts_mem   [DEPTH];

   logic              evt;
   logic              empty;
   logic              full;
   logic              pop;
   logic              push;
   logic [TS_W-1:0]   cap_ts;

   always_comb begin
      empty = (count_q == '0);
      full  = (count_q == FULL_CNT);
      evt   = en & (armed_q | (mon_data != prev_q));
      // clr wins over both sides of the FIFO; a pop frees the slot a full-cycle push needs
      pop   = ~clr & ~empty & trace.out_ready;
      push  = ~clr & evt & (~full | pop);
   end

`ifdef CHANGE_TRACE_DELTA_EN
   localparam logic [TS_W-1:0] TS_MAX = '1;

   logic [TS_W-1:0] delta_q, delta_d;

   // Every event, captured or dropped, restarts the delta reference
   always_comb begin
      delta_d = delta_q;
      if (clr) begin
         delta_d = '0;
      end else if (evt) begin
         delta_d = TS_W'(1);
      end else if (en && (delta_q != TS_MAX)) begin
         delta_d = delta_q + TS_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         delta_q <= '0;
      end else begin
         delta_q <= delta_d;
      end
   end

   assign cap_ts = armed_q ? ts_q : delta_q;
`else
   assign cap_ts = ts_q;
`endif

   always_comb begin
      ts_d       = ts_q;
      prev_d     = prev_q;
      armed_d    = armed_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      if (clr) begin
         ts_d       = '0;
         prev_d     = '0;
         armed_d    = 1'b1;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (en) begin
            ts_d   = ts_q + TS_W'(1);
            prev_d = mon_data;
         end
         if (evt) begin
            armed_d = 1'b0;
         end
         if (evt && !push) begin
            overflow_d = 1'b1;
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ts_q       <= '0;
         prev_q     <= '0;
         armed_q    <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         ts_q       <= ts_d;
         prev_q     <= prev_d;
         armed_q    <= armed_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset: nothing is read while the FIFO is empty
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr_q] <= mon_data;
         ts_mem[wr_ptr_q]   <= cap_ts;
      end
   end

   assign trace.out_valid = ~empty;
   assign trace.out_data  = empty ? '0 : data_mem[rd_ptr_q];
   assign trace.out_ts    = empty ? '0 : ts_mem[rd_ptr_q];
   assign count           = count_q;
   assign overflow        = overflow_q;

   a_count_range : assert property (@(posedge clk) disable iff (!rst_n)
      count_q <= FULL_CNT);

   a_head_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (trace.out_valid && !trace.out_ready && !clr) |=>
         ($stable(trace.out_data) && $stable(trace.out_ts)));

   a_overflow_sticky : assert property (@(posedge clk) disable iff (!rst_n)
      (overflow_q && !clr) |=> overflow_q);

endmodule
